int_ctrl: RTL

Programmed interrupt controller for the PDP-8/E core. It replaces the direct serial-interrupt-to-`irq` wiring and collects up to `NDEV` device interrupt lines. Each line is latched as a sticky pending bit and gated by a program-writable mask, and the block drives the single `irq` line into the state machine. It decodes its own IOT device code so the program can test, read, mask and clear requests. It returns data on a device bus to `imux` and returns a skip term.

---
 rtl/int_ctrl_if.sv | 36 +++
 rtl/int_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/int_ctrl_if.sv
// int_ctrl_if -- signal bundle between the PDP-8/E core and int_ctrl.
//
// Parameter:
//   NDEV         number of device request lines (1..12)
// Signals:
//   state        main state machine state               (core -> int_ctrl)
//   instruction  current instruction (mdout), [0:11]    (core -> int_ctrl)
//   ac           registered accumulator (rac), [0:11]   (core -> int_ctrl)
//   clear        CAF / front-panel clear, synchronous   (core -> int_ctrl)
//   dev_irq      device request levels, [0:NDEV-1]      (devices -> int_ctrl)
//   irq          interrupt request to the state machine (int_ctrl -> core)
//   skip         skip term to imux                      (int_ctrl -> core)
//   bus          data to the imux input bus, [0:11]     (int_ctrl -> core)
// Modports: master = core/bench side, slave = int_ctrl side.
interface int_ctrl_if #(
    parameter int NDEV = 4
);
    logic [4:0]      state;
    logic [0:11]     instruction;
    logic [0:11]     ac;
    logic            clear;
    logic [0:NDEV-1] dev_irq;
    logic            irq;
    logic            skip;
    logic [0:11]     bus;

    modport master (
        output state, instruction, ac, clear, dev_irq,
        input  irq, skip, bus
    );

    modport slave (
        input  state, instruction, ac, clear, dev_irq,
        output irq, skip, bus
    );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl -- programmed interrupt controller for the PDP-8/E core.
//
// Collects NDEV device request lines into sticky pending bits, gates them
// with a program-writable mask and drives the single irq line. Answers IOT
// device code DEVCODE for test/read/mask/clear operations, returning data on
// bus and a skip term.
//
// Parameters:
//   NDEV     number of request lines, 1..12; line 0 has highest priority
//   DEVCODE  IOT device code
//   IOT_ST   value of state while an IOT executes
// Ports:
//   clk      core clock
//   reset    asynchronous active-high reset
//   io       int_ctrl_if.slave (state, instruction, ac, clear, dev_irq in;
//            irq, skip, bus out)
// Build option:
//   INT_SYNC_EN  when defined, dev_irq goes through a 2-flop synchronizer
//                before edge detection (adds 2 cycles of capture latency).

// One request line: edge detect, sticky pending bit, mask bit.
module int_ctrl_line (
    input  logic clk,
    input  logic reset,
    input  logic cap_en,   // edge capture allowed this cycle
    input  logic clear,    // CAF / front-panel clear
    input  logic lvl,      // request level (possibly synchronized)
    input  logic msk_we,
    input  logic msk_d,
    input  logic clr,      // program clear of this pending bit
    output logic pending,
    output logic mask
);
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= 1'b0;
            pending <= 1'b0;
            mask    <= 1'b0;
        end else begin
            prev <= lvl;
            if (clear) begin
                pending <= 1'b0;
                mask    <= 1'b0;
            end else begin
                // a new edge wins over a same-cycle clear
                pending <= (cap_en & lvl & ~prev) | (pending & ~clr);
                if (msk_we) mask <= msk_d;
            end
        end
    end
endmodule

module int_ctrl #(
    parameter int         NDEV    = 4,
    parameter logic [5:0] DEVCODE = 6'o47,
    parameter logic [4:0] IOT_ST  = 5'd0
) (
    input logic       clk,
    input logic       reset,
    int_ctrl_if.slave io
);
    logic [0:NDEV-1] lvl, pending, mask, active, clr, ac_sel, msk_d;
    logic [3:0]      vec;
    logic [2:0]      op;
    logic            addressed, act, iot_seen, msk_we;
    logic            skip_q;
    logic [0:11]     bus_q, resp;
    logic            unused_ac;

`ifdef INT_SYNC_EN
    localparam int STG = 2;
    logic [0:NDEV-1] sync1, sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io.dev_irq;
            sync2 <= sync1;
        end
    end
    assign lvl = sync2;
`else
    localparam int STG = 0;
    assign lvl = io.dev_irq;
`endif

    // Edge capture stays off until prev holds a real post-reset sample
    // (and the synchronizer has filled), so lines already high at reset
    // release are not mistaken for new edges.
    localparam logic [STG:0] ARM_ONE = 1;
    logic [STG:0] arm_pipe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) arm_pipe <= '0;
        else       arm_pipe <= (arm_pipe << 1) | ARM_ONE;
    end

    assign addressed = (io.instruction[0:2] == 3'b110) &&
                       (io.instruction[3:8] == DEVCODE) &&
                       (io.state == IOT_ST);
    assign op        = io.instruction[9:11];
    assign act       = addressed & ~iot_seen;   // one action per instruction
    assign ac_sel    = io.ac[12-NDEV:11];
    assign unused_ac = ^io.ac;

    assign active = pending & mask;
    assign io.irq = |active;

    always_comb begin
        vec = 4'hF;
        for (int i = NDEV - 1; i >= 0; i--)
            if (active[i]) vec = 4'(i);
    end

    always_comb begin
        clr = '0;
        if (act) begin
            case (op)
                3'd4: clr = ac_sel;
                3'd5: for (int i = 0; i < NDEV; i++)
                          if (vec == 4'(i)) clr[i] = 1'b1;
                3'd7: clr = '1;
                default: ;
            endcase
        end
    end

    assign msk_we = act && (op == 3'd2 || op == 3'd7);
    assign msk_d  = (op == 3'd7) ? '0 : ac_sel;

    for (genvar i = 0; i < NDEV; i++) begin : g_line
        int_ctrl_line u_line (
            .clk     (clk),
            .reset   (reset),
            .cap_en  (arm_pipe[STG]),
            .clear   (io.clear),
            .lvl     (lvl[i]),
            .msk_we  (msk_we),
            .msk_d   (msk_d[i]),
            .clr     (clr[i]),
            .pending (pending[i]),
            .mask    (mask[i])
        );
    end

    // Response built from pre-action state, so RDP/VEC report the
    // values as they were before any same-cycle clear.
    always_comb begin
        resp = '0;
        case (op)
            3'd3: resp[12-NDEV:11] = pending;
            3'd5: resp[8:11]       = vec;
            3'd6: resp[12-NDEV:11] = mask;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iot_seen <= 1'b0;
            skip_q   <= 1'b0;
            bus_q    <= '0;
        end else if (!addressed) begin
            iot_seen <= 1'b0;
            skip_q   <= 1'b0;
            bus_q    <= '0;
        end else if (!iot_seen) begin
            iot_seen <= 1'b1;
            skip_q   <= (op == 3'd1) && (|active);
            bus_q    <= resp;
        end
    end

    assign io.skip = skip_q;
    assign io.bus  = bus_q;
endmodule
